// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared, pipelined ALU.
// A grant latches the winner's payload, issues it once, waits ALU_LAT cycles and returns the result.
module alu_arbiter #(
  parameter int INPUT   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0,
  input  logic                 REQ1,
  input  logic [3:0]           CMD0,
  input  logic [3:0]           CMD1,
  input  logic                 MODE0,
  input  logic                 MODE1,
  input  logic [INPUT-1:0]     OPA0,
  input  logic [INPUT-1:0]     OPA1,
  input  logic [INPUT-1:0]     OPB0,
  input  logic [INPUT-1:0]     OPB1,
  input  logic                 CIN0,
  input  logic                 CIN1,
  input  logic [1:0]           VALID0,
  input  logic [1:0]           VALID1,
  output logic                 ACK0,
  output logic                 ACK1,
  output logic [3:0]           ALU_CMD,
  output logic                 ALU_MODE,
  output logic [INPUT-1:0]     ALU_OPA,
  output logic [INPUT-1:0]     ALU_OPB,
  output logic                 ALU_CIN,
  output logic [1:0]           ALU_VALID,
  output logic                 ALU_CE,
  input  logic [2*INPUT-1:0]   ALU_RES,
  input  logic                 ALU_ERR,
  input  logic                 ALU_OFLOW,
  input  logic                 ALU_COUT,
  input  logic                 ALU_G,
  input  logic                 ALU_L,
  input  logic                 ALU_E,
  output logic                 RSP_VALID0,
  output logic                 RSP_VALID1,
  output logic [2*INPUT-1:0]   RSP_RES,
  output logic [5:0]           RSP_FLAGS,
  output logic                 BUSY
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic [2:0] LAT     = 3'(ALU_LAT);

  logic [1:0]         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               last_q, gnt_q;
  logic               ack0_q, ack1_q, ce_q, busy_q, rv0_q, rv1_q;
  logic [3:0]         cmd_q;
  logic               mode_q, cin_q;
  logic [INPUT-1:0]   opa_q, opb_q;
  logic [1:0]         valid_q;
  logic [2*INPUT-1:0] res_q;
  logic [5:0]         flags_q;
  logic               take, win1, capture;

  // Requester 1 wins when it is alone, or when both ask and 0 was served last.
  assign win1    = REQ1 && (!REQ0 || !last_q);
  assign capture = (state_q == S_WAIT) && (cnt_q == 3'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          take    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      ce_q      <= 1'b0;
      busy_q    <= 1'b0;
      rv0_q     <= 1'b0;
      rv1_q     <= 1'b0;
      cmd_q     <= '0;
      mode_q    <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      cin_q     <= 1'b0;
      valid_q   <= '0;
      res_q     <= '0;
      flags_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != S_IDLE);
      ack0_q  <= take && !win1;
      ack1_q  <= take && win1;
      ce_q    <= take;
      rv0_q   <= capture && !gnt_q;
      rv1_q   <= capture && gnt_q;
      // Payload registers double as the ALU drive and hold between issues.
      if (take) begin
        gnt_q   <= win1;
        last_q  <= win1;
        cmd_q   <= win1 ? CMD1   : CMD0;
        mode_q  <= win1 ? MODE1  : MODE0;
        opa_q   <= win1 ? OPA1   : OPA0;
        opb_q   <= win1 ? OPB1   : OPB0;
        cin_q   <= win1 ? CIN1   : CIN0;
        valid_q <= win1 ? VALID1 : VALID0;
      end
      if (capture) begin
        res_q   <= ALU_RES;
        flags_q <= {ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E};
      end
    end
  end

  assign ACK0       = ack0_q;
  assign ACK1       = ack1_q;
  assign ALU_CE     = ce_q;
  assign ALU_CMD    = cmd_q;
  assign ALU_MODE   = mode_q;
  assign ALU_OPA    = opa_q;
  assign ALU_OPB    = opb_q;
  assign ALU_CIN    = cin_q;
  assign ALU_VALID  = valid_q;
  assign RSP_VALID0 = rv0_q;
  assign RSP_VALID1 = rv1_q;
  assign RSP_RES    = res_q;
  assign RSP_FLAGS  = flags_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (ALU_LAT 1 and 3), each behind a toy pipelined ALU,
// checked every cycle against a transaction-schedule model of grants and responses.
`timescale 1ns/1ps
module tb_alu_arbiter;

  typedef struct packed {
    logic [3:0] cmd;
    logic       mode;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       cin;
    logic [1:0] valid;
  } pay_t;

  typedef struct packed {
    logic req0, req1;
    logic ack0, ack1, ce, busy, rv0, rv1;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i  [2];
  logic        req0_i [2];
  logic        req1_i [2];
  pay_t        pay_i  [2][2];
  logic        ack0_o [2], ack1_o [2], ce_o [2], busy_o [2], rv0_o [2], rv1_o [2];
  logic [3:0]  acmd_o [2];
  logic        amode_o [2], acin_o [2];
  logic [7:0]  aopa_o [2], aopb_o [2];
  logic [1:0]  avalid_o [2];
  logic [15:0] res_o [2];
  logic [5:0]  flags_o [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Toy ALU behaviour: any deterministic function of the whole payload will do.
  function automatic logic [15:0] alu_f(pay_t p);
    if (p.mode) return {p.cmd, 12'h000} + 16'(p.opa) + 16'(p.opb) + 16'(p.cin);
    return (16'(p.opa) * 16'(p.opb)) ^ {p.valid, p.cmd, 10'h000};
  endfunction

  function automatic logic [5:0] alu_g(pay_t p);
    return {p.opa[7], p.opb[0] ^ p.cin, p.mode, p.opa > p.opb, p.opa < p.opb, p.opa == p.opb};
  endfunction

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic pay_t rand_pay();
    return pay_t'(24'($urandom));
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : 3;
    pay_t        issued;
    logic [L-1:0] p_v;
    logic [15:0] p_res [L];
    logic [5:0]  p_fl [L];
    logic [15:0] junk_res, alu_res;
    logic [5:0]  junk_fl, alu_fl;

    assign issued = {acmd_o[gi], amode_o[gi], aopa_o[gi], aopb_o[gi], acin_o[gi], avalid_o[gi]};

    // Result is valid only L cycles after CE was sampled; noise otherwise.
    always @(posedge clk) begin
      p_v[0]   <= ce_o[gi];
      p_res[0] <= alu_f(issued);
      p_fl[0]  <= alu_g(issued);
      for (int k = 1; k < L; k++) begin
        p_v[k]   <= p_v[k-1];
        p_res[k] <= p_res[k-1];
        p_fl[k]  <= p_fl[k-1];
      end
      junk_res <= 16'($urandom);
      junk_fl  <= 6'($urandom);
    end

    assign alu_res = p_v[L-1] ? p_res[L-1] : junk_res;
    assign alu_fl  = p_v[L-1] ? p_fl[L-1]  : junk_fl;

    alu_arbiter #(.INPUT(8), .ALU_LAT(L)) u_dut (
      .CLK(clk), .RST(rst_i[gi]), .REQ0(req0_i[gi]), .REQ1(req1_i[gi]),
      .CMD0(pay_i[gi][0].cmd), .CMD1(pay_i[gi][1].cmd),
      .MODE0(pay_i[gi][0].mode), .MODE1(pay_i[gi][1].mode),
      .OPA0(pay_i[gi][0].opa), .OPA1(pay_i[gi][1].opa),
      .OPB0(pay_i[gi][0].opb), .OPB1(pay_i[gi][1].opb),
      .CIN0(pay_i[gi][0].cin), .CIN1(pay_i[gi][1].cin),
      .VALID0(pay_i[gi][0].valid), .VALID1(pay_i[gi][1].valid),
      .ACK0(ack0_o[gi]), .ACK1(ack1_o[gi]),
      .ALU_CMD(acmd_o[gi]), .ALU_MODE(amode_o[gi]), .ALU_OPA(aopa_o[gi]), .ALU_OPB(aopb_o[gi]),
      .ALU_CIN(acin_o[gi]), .ALU_VALID(avalid_o[gi]), .ALU_CE(ce_o[gi]),
      .ALU_RES(alu_res), .ALU_ERR(alu_fl[5]), .ALU_OFLOW(alu_fl[4]), .ALU_COUT(alu_fl[3]),
      .ALU_G(alu_fl[2]), .ALU_L(alu_fl[1]), .ALU_E(alu_fl[0]),
      .RSP_VALID0(rv0_o[gi]), .RSP_VALID1(rv1_o[gi]),
      .RSP_RES(res_o[gi]), .RSP_FLAGS(flags_o[gi]), .BUSY(busy_o[gi])
    );
  end

  // Reference model: per instance, the cycles at which the current operation's events happen.
  int          m_ack_at [2], m_rsp_at [2], m_free_at [2];
  logic        m_last [2], m_win [2];
  pay_t        m_pay [2], m_pay_hold [2];
  logic [15:0] m_res [2], m_res_hold [2];
  logic [5:0]  m_fl [2], m_fl_hold [2];

  task automatic cmp(string name, int d, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL d%0d.%s cycle %0d: got 'h%0h, expected 'h%0h", d, name, cyc, act, exp);
    end
  endtask

  task automatic model_reset(int d);
    m_ack_at[d]   = -1;
    m_rsp_at[d]   = -1;
    m_free_at[d]  = cyc + 1;
    m_last[d]     = 1'b1;
    m_win[d]      = 1'b0;
    m_pay_hold[d] = '0;
    m_res_hold[d] = '0;
    m_fl_hold[d]  = '0;
  endtask

  task automatic commit(int d);
    logic w;
    if (rst_i[d]) begin
      model_reset(d);
    end else if (cyc >= m_free_at[d] && (req0_i[d] || req1_i[d])) begin
      w = req1_i[d] && (!req0_i[d] || !m_last[d]);
      m_last[d]    = w;
      m_win[d]     = w;
      m_pay[d]     = pay_i[d][w];
      m_res[d]     = alu_f(pay_i[d][w]);
      m_fl[d]      = alu_g(pay_i[d][w]);
      m_ack_at[d]  = cyc + 1;
      m_rsp_at[d]  = cyc + 2 + lat_of(d);
      m_free_at[d] = cyc + 3 + lat_of(d);
    end
  endtask

  task automatic check(int d);
    logic e_ack, e_rsp, e_busy;
    e_ack  = (cyc == m_ack_at[d]);
    e_rsp  = (cyc == m_rsp_at[d]);
    e_busy = (cyc >= m_ack_at[d]) && (cyc <= m_rsp_at[d]);
    if (e_ack) m_pay_hold[d] = m_pay[d];
    if (e_rsp) begin
      m_res_hold[d] = m_res[d];
      m_fl_hold[d]  = m_fl[d];
      $display("d%0d cycle %0d: response to requester %0d res=%h flags=%b",
               d, cyc, m_win[d], res_o[d], flags_o[d]);
    end
    cmp("ack0", d, ack0_o[d], e_ack && !m_win[d]);
    cmp("ack1", d, ack1_o[d], e_ack && m_win[d]);
    cmp("alu_ce", d, ce_o[d], e_ack);
    cmp("busy", d, busy_o[d], e_busy);
    cmp("rsp_valid0", d, rv0_o[d], e_rsp && !m_win[d]);
    cmp("rsp_valid1", d, rv1_o[d], e_rsp && m_win[d]);
    cmp("alu_payload", d, {acmd_o[d], amode_o[d], aopa_o[d], aopb_o[d], acin_o[d], avalid_o[d]},
        m_pay_hold[d]);
    cmp("rsp_res", d, res_o[d], m_res_hold[d]);
    cmp("rsp_flags", d, flags_o[d], m_fl_hold[d]);
  endtask

  // Inputs for the current cycle are already driven; advance one clock and check.
  task automatic step();
    for (int d = 0; d < 2; d++) commit(d);
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) check(d);
  endtask

  function automatic vec_t mk(logic q0, q1, a0, a1, ce, bz, v0, v1);
    vec_t v;
    v = '{req0: q0, req1: q1, ack0: a0, ack1: a1, ce: ce, busy: bz, rv0: v0, rv1: v1};
    return v;
  endfunction

  initial begin
    vec_t tbl [18];
    pay_t p;
    int   t0, n;
    logic cur;
    logic acked;

    // Both requesters held: grants alternate 0,1,0,1 with ALU_CE every fourth cycle.
    tbl[0]  = mk(1,1, 0,0,0,0,0,0);  tbl[1]  = mk(1,1, 1,0,1,1,0,0);
    tbl[2]  = mk(1,1, 0,0,0,1,0,0);  tbl[3]  = mk(1,1, 0,0,0,1,1,0);
    tbl[4]  = mk(1,1, 0,0,0,0,0,0);  tbl[5]  = mk(1,1, 0,1,1,1,0,0);
    tbl[6]  = mk(1,1, 0,0,0,1,0,0);  tbl[7]  = mk(1,1, 0,0,0,1,0,1);
    tbl[8]  = mk(1,1, 0,0,0,0,0,0);  tbl[9]  = mk(1,1, 1,0,1,1,0,0);
    tbl[10] = mk(1,1, 0,0,0,1,0,0);  tbl[11] = mk(1,1, 0,0,0,1,1,0);
    tbl[12] = mk(1,1, 0,0,0,0,0,0);  tbl[13] = mk(0,0, 0,1,1,1,0,0);
    tbl[14] = mk(0,0, 0,0,0,1,0,0);  tbl[15] = mk(0,0, 0,0,0,1,0,1);
    tbl[16] = mk(0,0, 0,0,0,0,0,0);  tbl[17] = mk(0,0, 0,0,0,0,0,0);

    for (int d = 0; d < 2; d++) begin
      rst_i[d] = 1'b1;
      req0_i[d] = 1'b0;
      req1_i[d] = 1'b0;
      pay_i[d][0] = rand_pay();
      pay_i[d][1] = rand_pay();
      model_reset(d);
    end
    step();
    step();
    rst_i[0] = 1'b0;
    rst_i[1] = 1'b0;
    step();

    // Single request with the reference operands 255 + 255.
    pay_i[0][0] = '{cmd: 4'b0000, mode: 1'b1, opa: 8'd255, opb: 8'd255, cin: 1'b0, valid: 2'b11};
    req0_i[0] = 1'b1;
    step();
    cmp("s32_ack0_ce", 0, {ack0_o[0], ce_o[0]}, 2'b11);
    cmp("s32_opa_opb", 0, {aopa_o[0], aopb_o[0]}, 16'hFFFF);
    step();
    req0_i[0] = 1'b0;
    step();
    cmp("s32_rsp_valid0", 0, rv0_o[0], 1'b1);
    cmp("s32_rsp_res", 0, res_o[0], 16'h01FE);
    step();

    // Contention table straight after reset.
    pay_i[0][0] = rand_pay();
    pay_i[0][1] = rand_pay();
    rst_i[0] = 1'b1;
    step();
    rst_i[0] = 1'b0;
    for (int i = 0; i < 18; i++) begin
      cmp($sformatf("tbl%0d", i), 0, {ack0_o[0], ack1_o[0], ce_o[0], busy_o[0], rv0_o[0], rv1_o[0]},
          {tbl[i].ack0, tbl[i].ack1, tbl[i].ce, tbl[i].busy, tbl[i].rv0, tbl[i].rv1});
      req0_i[0] = tbl[i].req0;
      req1_i[0] = tbl[i].req1;
      step();
    end

    // Reset while the operation is in WAIT aborts it silently.
    req0_i[0] = 1'b1;
    step();
    step();
    req0_i[0] = 1'b0;
    rst_i[0] = 1'b1;
    step();
    rst_i[0] = 1'b0;
    cmp("s35_busy_ce", 0, {busy_o[0], ce_o[0]}, 2'b00);
    repeat (4) begin
      cmp("s35_no_rsp", 0, {rv0_o[0], rv1_o[0]}, 2'b00);
      step();
    end
    req1_i[0] = 1'b1;
    step();
    cmp("s35_ack1", 0, ack1_o[0], 1'b1);
    step();
    req1_i[0] = 1'b0;
    step();
    cmp("s35_rsp_valid1", 0, rv1_o[0], 1'b1);
    step();

    // Latency 3 instance: single REQ1.
    p = rand_pay();
    pay_i[1][1] = p;
    req1_i[1] = 1'b1;
    step();
    cmp("s36_ack1", 1, ack1_o[1], 1'b1);
    step();
    req1_i[1] = 1'b0;
    step();
    step();
    cmp("s36_no_early_rsp", 1, rv1_o[1], 1'b0);
    step();
    cmp("s36_rsp_valid1", 1, rv1_o[1], 1'b1);
    cmp("s36_rsp_flags", 1, flags_o[1], alu_g(p));
    step();

    // REQ0 dropped the cycle after ACK0: exactly one issue, then idle.
    n = 0;
    req0_i[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      n += int'(ce_o[0]);
      if (k == 2) req0_i[0] = 1'b0;
    end
    cmp("s37_issue_count", 0, n, 1);
    cmp("s37_busy", 0, busy_o[0], 1'b0);

    // Random traffic with occasional resets and abandoned requests.
    for (int k = 0; k < 800; k++) begin
      for (int d = 0; d < 2; d++) begin
        rst_i[d] = ($urandom_range(0, 99) == 0);
        for (int r = 0; r < 2; r++) begin
          cur   = (r == 0) ? req0_i[d] : req1_i[d];
          acked = (cyc == m_ack_at[d]) && (m_win[d] == 1'(r));
          if (!cur) begin
            if ($urandom_range(0, 2) == 0) begin
              pay_i[d][r] = rand_pay();
              cur = 1'b1;
            end
          end else if (acked) begin
            cur = ($urandom_range(0, 1) == 0);
          end else if ($urandom_range(0, 29) == 0) begin
            cur = 1'b0;
          end
          if (r == 0) req0_i[d] = cur;
          else        req1_i[d] = cur;
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Parameters
REQ-001 SHALL have parameter INPUT, default 8: operand width in bits, equal to the shared ALU's INPUT.
REQ-002 SHALL have parameter ALU_LAT, default 1, legal 1..4: cycles from the ALU sampling CE=1 to its RES/flags being valid.

Interface
REQ-003 SHALL have port CLK, input, 1: single clock, all state on its rising edge.
REQ-004 SHALL have port RST, input, 1: synchronous reset, active-high.
REQ-005 SHALL have ports REQ0 / REQ1, input, 1 each: request from requester 0 / 1, held until ACK.
REQ-006 SHALL have ports CMD0/CMD1 (4), MODE0/MODE1 (1), OPA0/OPA1 (INPUT), OPB0/OPB1 (INPUT), CIN0/CIN1 (1) and VALID0/VALID1 (2), all inputs: per-requester operation payload, stable while REQ is high.
REQ-007 SHALL have ports ACK0 / ACK1, output, 1 each: one-cycle pulse, payload accepted.
REQ-008 SHALL have ports ALU_CMD (4), ALU_MODE (1), ALU_OPA (INPUT), ALU_OPB (INPUT), ALU_CIN (1), ALU_VALID (2) and ALU_CE (1), all outputs: registered drive to the shared ALU.
REQ-009 SHALL have ports ALU_RES (2*INPUT) and ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E (1 each), all inputs: ALU results.
REQ-010 SHALL have ports RSP_VALID0 / RSP_VALID1, output, 1 each: one-cycle response strobe to requester 0 / 1.
REQ-011 SHALL have port RSP_RES, output, 2*INPUT: captured result, shared by both requesters.
REQ-012 SHALL have port RSP_FLAGS, output, 6: captured {ERR,OFLOW,COUT,G,L,E}, shared by both requesters.
REQ-013 SHALL have port BUSY, output, 1: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, ISSUE, WAIT and RESP; every output SHALL be registered.
REQ-015 IDLE: with any REQ high, SHALL select a winner, latch its payload, pulse the winner's ACK in the next cycle and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: a single requester wins; with both requesting, the requester other than LAST wins; LAST SHALL be updated to the winner on every grant.
REQ-017 ISSUE (exactly 1 cycle): ALU_CE=1 with the latched payload on the ALU_* outputs; SHALL load the wait counter with ALU_LAT and go to WAIT.
REQ-018 WAIT: the counter SHALL decrement each cycle; in the cycle where the counter equals 1, the block SHALL capture ALU_RES and the six flags into RSP_RES/RSP_FLAGS and go to RESP.
REQ-019 RESP (1 cycle): RSP_VALID of the granted requester only SHALL be 1, then the FSM SHALL go to IDLE.
REQ-020 Latency, REQ first sampled in IDLE at cycle 0: ACK and ALU_CE SHALL be high in cycle 1, and RSP_VALID SHALL be high in cycle 2+ALU_LAT.
REQ-021 A requester that keeps REQ high through RESP SHALL be treated as making a new request when the FSM is next in IDLE.
REQ-022 Back-to-back service SHALL achieve one operation per 3+ALU_LAT cycles.
REQ-023 ALU_CE SHALL be 0 in every state except ISSUE.
REQ-024 ALU_* payload outputs SHALL hold their last value outside ISSUE.
REQ-025 RSP_RES/RSP_FLAGS SHALL hold until the next capture.
REQ-026 ACK0&ACK1 and RSP_VALID0&RSP_VALID1 SHALL never be high together.
REQ-027 REQ inputs SHALL be ignored in ISSUE, WAIT and RESP; a request dropped before its ACK SHALL be lost with no error.
REQ-028 The block SHALL pass results through unmodified and SHALL perform no arithmetic on them.

Reset
REQ-029 On RST=1 at a clock edge, the FSM SHALL enter IDLE and LAST SHALL be set to 1, so requester 0 wins the first contention.
REQ-030 On reset, every output (ACKs, RSP_VALIDs, ALU_CE, BUSY, ALU_* payload, RSP_RES, RSP_FLAGS) SHALL be 0 and the wait counter SHALL be cleared.
REQ-031 Reset during ISSUE/WAIT/RESP SHALL abort the in-flight operation, with no RSP_VALID and no ACK issued for it; RST SHALL take priority over all requests.

Verification (ALU_LAT=1 unless stated)
REQ-032 REQ0, CMD0=0000, MODE0=1, OPA0=255, OPB0=255, CIN0=0, VALID0=11 -> ACK0 and ALU_CE in cycle 1 with ALU_OPA=ALU_OPB=255; RSP_VALID0 in cycle 3 with RSP_RES = ALU_RES as returned (0x01FE from ALU1).
REQ-033 REQ0 and REQ1 both raised in the same cycle after reset -> requester 0 is served first and requester 1 second; the ACKs and RSP_VALIDs never overlap.
REQ-034 REQ0 and REQ1 held continuously -> grant order 0,1,0,1; ALU_CE pulses exactly every 4 cycles.
REQ-035 RST pulsed while in WAIT -> next cycle BUSY=0 and ALU_CE=0, no RSP_VALID follows, and a subsequent REQ1 completes with normal latency.
REQ-036 ALU_LAT=3, a single REQ1 -> ACK1 in cycle 1, RSP_VALID1 in cycle 5, RSP_FLAGS equal to the ALU flags sampled in the cycle before RSP_VALID.
REQ-037 REQ0 dropped in the cycle after ACK0, REQ1 idle -> exactly one operation issued; the FSM returns to IDLE with BUSY=0.
